// File: rtl/id_pkg.sv
// Shared definitions for the two-channel identifier recognizer.
// Holds the recognizer state constants, the character-class encoding and
// the range functions that classify an ASCII character.
package id_pkg;

  localparam int unsigned ST_W   = 2;
  localparam int unsigned CHAR_W = 8;

  // Recognizer states; 2'b11 is never written and decodes as S0.
  localparam logic [ST_W-1:0] S0 = 2'b00;
  localparam logic [ST_W-1:0] S1 = 2'b01;
  localparam logic [ST_W-1:0] S2 = 2'b10;

  typedef enum logic [1:0] {
    CLS_OTHER  = 2'd0,
    CLS_LETTER = 2'd1,
    CLS_DIGIT  = 2'd2
  } char_class_t;

  // 'A'..'Z' or 'a'..'z'
  function automatic logic is_letter(input logic [CHAR_W-1:0] c);
    return ((c >= 8'd65) && (c <= 8'd90)) || ((c >= 8'd97) && (c <= 8'd122));
  endfunction

  // '0'..'9'
  function automatic logic is_digit(input logic [CHAR_W-1:0] c);
    return (c >= 8'd48) && (c <= 8'd57);
  endfunction

  function automatic char_class_t classify(input logic [CHAR_W-1:0] c);
    char_class_t cls;
    cls = CLS_OTHER;
    if (is_letter(c)) begin
      cls = CLS_LETTER;
    end else if (is_digit(c)) begin
      cls = CLS_DIGIT;
    end
    return cls;
  endfunction

endpackage

// File: rtl/id_step.sv
// Combinational identifier-recognizer step: (state, char) -> next state.
// Ports:
//   state  in  ST_W    current recognizer state (2'b11 treated as S0)
//   chr    in  CHAR_W  ASCII character being consumed
//   nxt    out ST_W    next recognizer state
module id_step
  import id_pkg::*;
(
  input  logic [ST_W-1:0]   state,
  input  logic [CHAR_W-1:0] chr,
  output logic [ST_W-1:0]   nxt
);

  char_class_t cls;

  assign cls = classify(chr);

  // A letter always lands in S1; a digit only keeps an identifier alive
  // (S1/S2 -> S2); anything else drops back to S0.
  always_comb begin
    nxt = S0;
    case (state)
      S1, S2: begin
        case (cls)
          CLS_LETTER: nxt = S1;
          CLS_DIGIT:  nxt = S2;
          default:    nxt = S0;
        endcase
      end
      default: begin
        if (cls == CLS_LETTER) begin
          nxt = S1;
        end
      end
    endcase
  end

endmodule

// File: rtl/id_arb.sv
// Two-channel round-robin scheduler sharing one identifier-recognizer step.
// Each cycle at most one channel is granted; its saved state is advanced by
// the shared id_step and the result is reported one cycle later.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   char0/char1         offered ASCII characters
//   valid0/valid1       character offered this cycle
//   ready0/ready1       character consumed this cycle (combinational grant)
//   clr0/clr1           force channel state to S0 at the next edge
//   out0/out1           channel saved state == S2 (registered)
//   res_valid/res_ch    a step completed last cycle, and on which channel
//   res_state/res_out   new state of that step, and whether it is S2
//   cnt0/cnt1           saturating count of S1->S2 entries per channel
module id_arb
  import id_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        char0,
  input  logic [7:0]        char1,
  input  logic              valid0,
  input  logic              valid1,
  output logic              ready0,
  output logic              ready1,
  input  logic              clr0,
  input  logic              clr1,
  output logic              out0,
  output logic              out1,
  output logic              res_valid,
  output logic              res_ch,
  output logic [1:0]        res_state,
  output logic              res_out,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [ST_W-1:0]   st0;
  logic [ST_W-1:0]   st1;
  logic              last_grant;
  logic              elig0;
  logic              elig1;
  logic              gnt0;
  logic              gnt1;
  logic [ST_W-1:0]   st_sel;
  logic [CHAR_W-1:0] char_sel;
  logic [ST_W-1:0]   st_nxt;
  logic              rise;

  // A channel being cleared does not compete for the step this cycle.
  assign elig0 = valid0 & ~clr0;
  assign elig1 = valid1 & ~clr1;

  // Round-robin: on a tie, grant the channel that did not win last time.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (elig0 && elig1) begin
        gnt0 = last_grant;
        gnt1 = ~last_grant;
      end else begin
        gnt0 = elig0;
        gnt1 = elig1;
      end
    end
  end

  assign ready0 = gnt0;
  assign ready1 = gnt1;

  // Shared datapath input mux, steered by the grant.
  assign st_sel   = gnt1 ? st1   : st0;
  assign char_sel = gnt1 ? char1 : char0;

  id_step u_step (
    .state (st_sel),
    .chr   (char_sel),
    .nxt   (st_nxt)
  );

  // Counted event: the granted step enters S2 from S1.
  assign rise = (st_sel == S1) && (st_nxt == S2);

  // State registers, counters and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st0        <= S0;
      st1        <= S0;
      out0       <= 1'b0;
      out1       <= 1'b0;
      cnt0       <= '0;
      cnt1       <= '0;
      last_grant <= 1'b1;
      res_valid  <= 1'b0;
      res_ch     <= 1'b0;
      res_state  <= S0;
      res_out    <= 1'b0;
    end else begin
      res_valid <= gnt0 | gnt1;
      if (gnt0 || gnt1) begin
        last_grant <= gnt1;
        res_ch     <= gnt1;
        res_state  <= st_nxt;
        res_out    <= (st_nxt == S2);
      end

      if (clr0) begin
        st0  <= S0;
        out0 <= 1'b0;
      end else if (gnt0) begin
        st0  <= st_nxt;
        out0 <= (st_nxt == S2);
        if (rise && (cnt0 != CNT_MAX)) begin
          cnt0 <= cnt0 + CNT_W'(1);
        end
      end

      if (clr1) begin
        st1  <= S0;
        out1 <= 1'b0;
      end else if (gnt1) begin
        st1  <= st_nxt;
        out1 <= (st_nxt == S2);
        if (rise && (cnt1 != CNT_MAX)) begin
          cnt1 <= cnt1 + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_id_arb.sv
// Self-checking bench for id_arb with a behavioural reference model.
module tb_id_arb;

  localparam int unsigned TB_CNT_W = 2;
  localparam int unsigned VEC_W    = 2 + 7 + 2 * TB_CNT_W;

  logic                clk;
  logic                rst_n;
  logic [7:0]          char0, char1;
  logic                valid0, valid1;
  logic                ready0, ready1;
  logic                clr0, clr1;
  logic                out0, out1;
  logic                res_valid, res_ch;
  logic [1:0]          res_state;
  logic                res_out;
  logic [TB_CNT_W-1:0] cnt0, cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  id_arb #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .char0(char0), .char1(char1),
    .valid0(valid0), .valid1(valid1),
    .ready0(ready0), .ready1(ready1),
    .clr0(clr0), .clr1(clr1),
    .out0(out0), .out1(out1),
    .res_valid(res_valid), .res_ch(res_ch),
    .res_state(res_state), .res_out(res_out),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int m_st[2];
  int m_cnt[2];
  int m_last;
  bit m_rv;
  int m_rch;
  int m_rst;
  logic [1:0] exp_rdy;
  logic [1:0] obs_rdy;

  // Identifier recognition: letters (re)start an identifier, digits extend
  // an identifier already begun, anything else ends it.
  function automatic int m_next(input int s, input logic [7:0] c);
    bit let_c, dig_c;
    let_c = (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
    dig_c = (c >= 8'h30 && c <= 8'h39);
    if (let_c) return 1;
    if (dig_c && (s == 1 || s == 2)) return 2;
    return 0;
  endfunction

  function automatic logic [VEC_W-3:0] exp_vec();
    return {m_st[0] == 2, m_st[1] == 2, m_rv, m_rch[0], 2'(m_rst), m_rst == 2,
            TB_CNT_W'(m_cnt[0]), TB_CNT_W'(m_cnt[1])};
  endfunction

  function automatic logic [VEC_W-3:0] dut_vec();
    return {out0, out1, res_valid, res_ch, res_state, res_out, cnt0, cnt1};
  endfunction

  // Drive one cycle, capture ready before the edge, advance the model.
  task automatic step(input logic v0, input logic [7:0] c0, input logic k0,
                      input logic v1, input logic [7:0] c1, input logic k1);
    bit e0, e1, g0, g1;
    int ns;
    valid0 = v0; char0 = c0; clr0 = k0;
    valid1 = v1; char1 = c1; clr1 = k1;
    #2;
    obs_rdy = {ready0, ready1};
    e0 = v0 && !k0;
    e1 = v1 && !k1;
    g0 = 0; g1 = 0;
    if (rst_n) begin
      if (e0 && e1) begin
        g0 = (m_last == 1);
        g1 = (m_last == 0);
      end else begin
        g0 = e0;
        g1 = e1;
      end
    end
    exp_rdy = {g0, g1};
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_st = '{0, 0}; m_cnt = '{0, 0}; m_last = 1;
      m_rv = 0; m_rch = 0; m_rst = 0;
    end else begin
      m_rv = g0 || g1;
      if (g0 || g1) begin
        int ch;
        ch = g1 ? 1 : 0;
        ns = m_next(m_st[ch], ch ? c1 : c0);
        if (m_st[ch] == 1 && ns == 2 && m_cnt[ch] < (1 << TB_CNT_W) - 1)
          m_cnt[ch]++;
        m_st[ch] = ns;
        m_last = ch;
        m_rch = ch;
        m_rst = ns;
      end
      if (k0) m_st[0] = 0;
      if (k1) m_st[1] = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(0, 8'h00, 0, 0, 8'h00, 0);
    step(0, 8'h00, 0, 0, 8'h00, 0);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    step(1, 8'h61, 0, 1, 8'h62, 0);
    n_tests++;
    if ({obs_rdy, dut_vec()} !== {2'b00, VEC_W'(0)}) begin
      n_fail++;
      $display("FAIL reset: got %b want %b", {obs_rdy, dut_vec()}, {2'b00, VEC_W'(0)});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ch0_only();
    logic [7:0] seq [4];
    logic [1:0] want [4];
    seq  = '{8'h61, 8'h62, 8'h31, 8'h32};
    want = '{2'b01, 2'b01, 2'b10, 2'b10};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, seq[i], 0, 0, 8'h00, 0);
      n_tests++;
      if ({obs_rdy, dut_vec()} !== {exp_rdy, exp_vec()} || res_state !== want[i]) begin
        n_fail++;
        $display("FAIL ch0_only[%0d]: got %b st=%0d want %b st=%0d", i,
                 {obs_rdy, dut_vec()}, res_state, {exp_rdy, exp_vec()}, want[i]);
      end
    end
    n_tests++;
    if ({out0, out1, cnt0} !== {1'b1, 1'b0, TB_CNT_W'(1)}) begin
      n_fail++;
      $display("FAIL ch0_only_end: out0=%b out1=%b cnt0=%0d want 1 0 1", out0, out1, cnt0);
    end
  endtask

  task automatic test_alternate();
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    int k;
    q0 = '{8'h78, 8'h39};
    q1 = '{8'h51, 8'h37};
    k = 0;
    do_reset();
    while ((q0.size() > 0 || q1.size() > 0) && k < 20) begin
      step(q0.size() > 0, q0.size() > 0 ? q0[0] : 8'h00, 0,
           q1.size() > 0, q1.size() > 0 ? q1[0] : 8'h00, 0);
      n_tests++;
      if ({obs_rdy, dut_vec()} !== {exp_rdy, exp_vec()} || res_ch !== 1'(k % 2)
          || res_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL alternate[%0d]: got %b ch=%b want %b ch=%0d", k,
                 {obs_rdy, dut_vec()}, res_ch, {exp_rdy, exp_vec()}, k % 2);
      end
      if (obs_rdy[1] && q0.size() > 0) void'(q0.pop_front());
      if (obs_rdy[0] && q1.size() > 0) void'(q1.pop_front());
      k++;
    end
    n_tests++;
    if (k != 4 || {out0, out1, cnt0, cnt1} !== {1'b1, 1'b1, TB_CNT_W'(1), TB_CNT_W'(1)}) begin
      n_fail++;
      $display("FAIL alternate_end: cycles=%0d out=%b%b cnt=%0d,%0d want 4 11 1,1",
               k, out0, out1, cnt0, cnt1);
    end
  endtask

  task automatic test_clear();
    do_reset();
    step(1, 8'h61, 0, 0, 8'h00, 0);
    step(1, 8'h31, 0, 0, 8'h00, 0);
    step(1, 8'h32, 1, 0, 8'h00, 0);
    n_tests++;
    if ({obs_rdy, out0, res_valid, cnt0} !== {2'b00, 1'b0, 1'b0, TB_CNT_W'(1)}
        || {obs_rdy, dut_vec()} !== {exp_rdy, exp_vec()}) begin
      n_fail++;
      $display("FAIL clear: rdy=%b out0=%b rv=%b cnt0=%0d want 00 0 0 1",
               obs_rdy, out0, res_valid, cnt0);
    end
    // Cleared channel restarts from S0: a digit now stays in S0.
    step(1, 8'h32, 0, 0, 8'h00, 0);
    n_tests++;
    if (res_state !== 2'b00 || {obs_rdy, dut_vec()} !== {exp_rdy, exp_vec()}) begin
      n_fail++;
      $display("FAIL clear_restart: st=%0d want 0", res_state);
    end
  endtask

  task automatic test_boundary();
    logic [7:0] oth [6];
    logic [7:0] cls [6];
    logic [1:0] cls_want [6];
    oth = '{8'h40, 8'h5B, 8'h60, 8'h7B, 8'h2F, 8'h3A};
    cls = '{8'h41, 8'h5A, 8'h61, 8'h7A, 8'h30, 8'h39};
    cls_want = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(0, 8'h00, 0, 1, oth[i], 0);
      n_tests++;
      if (res_state !== 2'b00 || {obs_rdy, dut_vec()} !== {exp_rdy, exp_vec()}) begin
        n_fail++;
        $display("FAIL boundary_s0[%0d]: st=%0d want 0", i, res_state);
      end
      step(0, 8'h00, 0, 1, 8'h6B, 0);
      step(0, 8'h00, 0, 1, oth[i], 0);
      n_tests++;
      if (res_state !== 2'b00 || {obs_rdy, dut_vec()} !== {exp_rdy, exp_vec()}) begin
        n_fail++;
        $display("FAIL boundary_s1[%0d]: st=%0d want 0", i, res_state);
      end
    end
    for (int i = 0; i < 6; i++) begin
      step(0, 8'h00, 0, 1, 8'h6B, 0);
      step(0, 8'h00, 0, 1, cls[i], 0);
      n_tests++;
      if (res_state !== cls_want[i] || {obs_rdy, dut_vec()} !== {exp_rdy, exp_vec()}) begin
        n_fail++;
        $display("FAIL class[%0d]: st=%0d want %0d", i, res_state, cls_want[i]);
      end
    end
  endtask

  task automatic test_saturate();
    logic [7:0] pat [3];
    pat = '{8'h61, 8'h31, 8'h20};
    do_reset();
    for (int r = 0; r < 5; r++)
      for (int j = 0; j < 3; j++)
        step(0, 8'h00, 0, 1, pat[j], 0);
    n_tests++;
    if (cnt1 !== TB_CNT_W'(3) || {obs_rdy, dut_vec()} !== {exp_rdy, exp_vec()}) begin
      n_fail++;
      $display("FAIL saturate: cnt1=%0d want 3", cnt1);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] seq [4];
    seq = '{8'h61, 8'h31, 8'h61, 8'h31};
    do_reset();
    for (int i = 0; i < 4; i++) step(1, seq[i], 0, 0, 8'h00, 0);
    n_tests++;
    if ({out0, cnt0} !== {1'b1, TB_CNT_W'(2)}) begin
      n_fail++;
      $display("FAIL reset_mid_pre: out0=%b cnt0=%0d want 1 2", out0, cnt0);
    end
    rst_n = 1'b0;
    step(1, 8'h62, 0, 1, 8'h63, 0);
    rst_n = 1'b1;
    n_tests++;
    if ({obs_rdy, dut_vec()} !== {2'b00, VEC_W'(0)}) begin
      n_fail++;
      $display("FAIL reset_mid: got %b want %b", {obs_rdy, dut_vec()}, {2'b00, VEC_W'(0)});
    end
    step(1, 8'h62, 0, 1, 8'h63, 0);
    n_tests++;
    if (obs_rdy !== 2'b10 || res_ch !== 1'b0 || {obs_rdy, dut_vec()} !== {exp_rdy, exp_vec()}) begin
      n_fail++;
      $display("FAIL reset_mid_tie: rdy=%b ch=%b want 10 0", obs_rdy, res_ch);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [16];
    bit pv [2];
    logic [7:0] pc [2];
    bit kc [2];
    int errs;
    pool = '{8'h40, 8'h41, 8'h5A, 8'h5B, 8'h60, 8'h61, 8'h7A, 8'h7B,
             8'h2F, 8'h30, 8'h39, 8'h3A, 8'h20, 8'h6D, 8'h35, 8'h4B};
    pv = '{0, 0};
    errs = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (!pv[c] && $urandom_range(0, 3) != 0) begin
          pv[c] = 1;
          pc[c] = pool[$urandom_range(0, 15)];
        end
        kc[c] = ($urandom_range(0, 9) == 0);
      end
      step(pv[0], pc[0], kc[0], pv[1], pc[1], kc[1]);
      n_tests++;
      if ({obs_rdy, dut_vec()} !== {exp_rdy, exp_vec()}) begin
        n_fail++;
        if (errs < 10)
          $display("FAIL random[%0d]: got %b want %b", i,
                   {obs_rdy, dut_vec()}, {exp_rdy, exp_vec()});
        errs++;
      end
      if (exp_rdy[1]) pv[0] = 0;
      if (exp_rdy[0]) pv[1] = 0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    valid0 = 0; valid1 = 0; clr0 = 0; clr1 = 0;
    char0 = 8'h00; char1 = 8'h00;
    m_st = '{0, 0}; m_cnt = '{0, 0}; m_last = 1;
    m_rv = 0; m_rch = 0; m_rst = 0;
    @(negedge clk);
    test_reset();
    test_ch0_only();
    test_alternate();
    test_clear();
    test_boundary();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
